// File: rtl/br_ram_init_checker.sv
// br_ram_init_checker: walks RAM addresses 0..Depth-1 and compares every returned word with a captured expected value.
// Latency: the first request goes out the cycle after start; done pulses the cycle after the last response is taken.
// Backpressure: with BR_RAM_INIT_CHECKER_STALL_EN, a request holds while rd_addr_ready is low; responses are never stalled.
//
// Optional feature macro: BR_RAM_INIT_CHECKER_STALL_EN (adds the rd_addr_ready input).
// Ports:
//   clk, rst_n                        clock, asynchronous active-low reset
//   expected_value, start             sweep request; the value is captured when start is accepted in IDLE
//   busy, done, pass                  sweep status; done is a one-cycle pulse and pass is valid from done onward
//   rd_addr_valid, rd_addr            read request stream (rd_addr_ready as well when stalls are enabled)
//   rd_data_valid, rd_data            in-order read responses with any latency
//   error_count, first_error_*        mismatch statistics, held until the next start
module br_ram_init_checker #(
    parameter int Depth = 2,
    parameter int Width = 1,
    localparam int AddressWidth = $clog2(Depth),
    localparam int CountWidth = $clog2(Depth + 1)
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [Width-1:0]        expected_value,
    input  logic                    start,
    output logic                    busy,
    output logic                    done,
    output logic                    pass,
    output logic                    rd_addr_valid,
    output logic [AddressWidth-1:0] rd_addr,
`ifdef BR_RAM_INIT_CHECKER_STALL_EN
    input  logic                    rd_addr_ready,
`endif
    input  logic                    rd_data_valid,
    input  logic [Width-1:0]        rd_data,
    output logic [CountWidth-1:0]   error_count,
    output logic                    first_error_valid,
    output logic [AddressWidth-1:0] first_error_addr,
    output logic [Width-1:0]        first_error_data
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DRAIN = 2'd2
    } state_t;

    localparam logic [AddressWidth-1:0] LastAddr = AddressWidth'(Depth - 1);
    localparam logic [AddressWidth-1:0] AddrOne  = AddressWidth'(1);
    localparam logic [CountWidth-1:0]   MaxCount = CountWidth'(Depth);
    localparam logic [CountWidth-1:0]   CountOne = CountWidth'(1);

    state_t                  state;
    state_t                  state_nxt;
    logic [Width-1:0]        expected_q;
    logic [AddressWidth-1:0] resp_idx;
    logic                    start_acc;
    logic                    req_acc;
    logic                    resp_acc;
    logic                    resp_last;
    logic                    mismatch;

    assign start_acc     = (state == IDLE) && start;
    assign busy          = (state != IDLE);
    assign rd_addr_valid = (state == ISSUE);
`ifdef BR_RAM_INIT_CHECKER_STALL_EN
    assign req_acc       = rd_addr_valid && rd_addr_ready;
`else
    assign req_acc       = rd_addr_valid;
`endif
    // Responses that arrive in IDLE are stale (for example, after a reset in the middle of a sweep), so they are dropped.
    assign resp_acc      = rd_data_valid && (state != IDLE);
    assign resp_last     = resp_acc && (resp_idx == LastAddr);
    assign mismatch      = resp_acc && (rd_data != expected_q);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (start) state_nxt = ISSUE;
            end
            ISSUE: begin
                // With a zero-latency RAM, the last response can arrive in the same cycle as the last request.
                if (resp_last) begin
                    state_nxt = IDLE;
                end else if (req_acc && (rd_addr == LastAddr)) begin
                    state_nxt = DRAIN;
                end
            end
            DRAIN: begin
                if (resp_last) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            done              <= 1'b0;
            pass              <= 1'b0;
            rd_addr           <= '0;
            resp_idx          <= '0;
            expected_q        <= '0;
            error_count       <= '0;
            first_error_valid <= 1'b0;
            first_error_addr  <= '0;
            first_error_data  <= '0;
        end else begin
            done <= resp_last;
            if (start_acc) begin
                expected_q        <= expected_value;
                rd_addr           <= '0;
                resp_idx          <= '0;
                pass              <= 1'b0;
                error_count       <= '0;
                first_error_valid <= 1'b0;
                first_error_addr  <= '0;
                first_error_data  <= '0;
            end else begin
                // The address stops at the last entry; only a new start sends it back to zero.
                if (req_acc && (rd_addr != LastAddr)) begin
                    rd_addr <= rd_addr + AddrOne;
                end
                if (resp_acc) begin
                    resp_idx <= resp_last ? '0 : resp_idx + AddrOne;
                end
                if (mismatch && (error_count != MaxCount)) begin
                    error_count <= error_count + CountOne;
                end
                if (mismatch && !first_error_valid) begin
                    first_error_valid <= 1'b1;
                    first_error_addr  <= resp_idx;
                    first_error_data  <= rd_data;
                end
                if (resp_last) begin
                    // This test includes the final response, whose mismatch has not yet been added to error_count.
                    pass <= (error_count == '0) && !mismatch;
                end
            end
        end
    end

    a_addr_in_range: assert property (@(posedge clk) disable iff (!rst_n) rd_addr <= LastAddr);
    c_stray_response: cover property (@(posedge clk) disable iff (!rst_n) rd_data_valid && (state == IDLE));

endmodule

// File: tb/tb_br_ram_init_checker.sv
// tb_br_ram_init_checker: checks a Depth-4 and a Depth-3 checker against a RAM model with 0..3 cycles of read latency.
// Latency: the expected request, response and done timing comes from the RAM model's cycle counts.
// Backpressure: when BR_RAM_INIT_CHECKER_STALL_EN is defined, the bench drives rd_addr_ready in fixed or random patterns.
module tb_br_ram_init_checker;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic       sel;        // 0 selects the Depth-4 instance, 1 selects the Depth-3 instance
    logic       start_a, start_b, rdy, extra_vld;
    logic [7:0] expv;
    logic [7:0] ram [4];
    int         lat;

    logic a_busy, a_done, a_pass, a_vld, a_fev;
    logic [1:0] a_addr, a_fea;
    logic [2:0] a_cnt;
    logic [7:0] a_fed;
    logic b_busy, b_done, b_pass, b_vld, b_fev;
    logic [1:0] b_addr, b_fea, b_cnt;
    logic [7:0] b_fed;

    logic m_busy, m_done, m_pass, m_vld, m_fev;
    logic [1:0] m_addr, m_fea;
    logic [2:0] m_cnt;
    logic [7:0] m_fed;

    always_comb begin
        if (sel) begin
            m_busy = b_busy; m_done = b_done; m_pass = b_pass; m_vld = b_vld; m_fev = b_fev;
            m_addr = b_addr; m_fea = b_fea; m_cnt = {1'b0, b_cnt}; m_fed = b_fed;
        end else begin
            m_busy = a_busy; m_done = a_done; m_pass = a_pass; m_vld = a_vld; m_fev = a_fev;
            m_addr = a_addr; m_fea = a_fea; m_cnt = a_cnt; m_fed = a_fed;
        end
    end

    // RAM model: an accepted request returns its data lat cycles later; lat = 0 returns it in the same cycle.
    logic       acc, rdv, rdv_a, rdv_b;
    logic [7:0] rdd;
    logic       pv [4];
    logic [7:0] pd [4];
    assign acc = m_vld && rdy;

    always @(posedge clk) begin
        pv[0] <= acc;
        pd[0] <= ram[m_addr];
        for (int i = 1; i < 4; i++) begin
            pv[i] <= pv[i-1];
            pd[i] <= pd[i-1];
        end
    end

    always_comb begin
        if (lat == 0) begin
            rdv = acc;
            rdd = ram[m_addr];
        end else begin
            rdv = pv[lat-1];
            rdd = pd[lat-1];
        end
        rdv = rdv | extra_vld;
    end
    assign rdv_a = rdv && !sel;
    assign rdv_b = rdv && sel;

    br_ram_init_checker #(.Depth(4), .Width(8)) u_a (
        .clk(clk), .rst_n(rst_n), .expected_value(expv), .start(start_a),
        .busy(a_busy), .done(a_done), .pass(a_pass), .rd_addr_valid(a_vld), .rd_addr(a_addr),
`ifdef BR_RAM_INIT_CHECKER_STALL_EN
        .rd_addr_ready(rdy),
`endif
        .rd_data_valid(rdv_a), .rd_data(rdd), .error_count(a_cnt),
        .first_error_valid(a_fev), .first_error_addr(a_fea), .first_error_data(a_fed)
    );

    br_ram_init_checker #(.Depth(3), .Width(8)) u_b (
        .clk(clk), .rst_n(rst_n), .expected_value(expv), .start(start_b),
        .busy(b_busy), .done(b_done), .pass(b_pass), .rd_addr_valid(b_vld), .rd_addr(b_addr),
`ifdef BR_RAM_INIT_CHECKER_STALL_EN
        .rd_addr_ready(rdy),
`endif
        .rd_data_valid(rdv_b), .rd_data(rdd), .error_count(b_cnt),
        .first_error_valid(b_fev), .first_error_addr(b_fea), .first_error_data(b_fed)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
        end
    endtask

    // Reference model: count the swept entries that differ from ev and record the first one that does.
    function automatic void model(input bit d3, input logic [31:0] img, input logic [7:0] ev,
                                  output int errs, output bit fv, output int fa, output logic [7:0] fd);
        errs = 0; fv = 0; fa = 0; fd = 8'h00;
        for (int i = 0; i < (d3 ? 3 : 4); i++) begin
            if (img[8*i +: 8] != ev) begin
                if (!fv) begin
                    fv = 1; fa = i; fd = img[8*i +: 8];
                end
                errs++;
            end
        end
    endfunction

    // rmode: 0 = always ready, 1 = random stalls, 2 = ready held low for two cycles while the address is 1.
    task automatic sweep(input string nm, input bit d3, input logic [31:0] img, input logic [7:0] ev,
                         input int l, input int rmode, input bit poke, input bit chained,
                         input bit chain_out, input logic [7:0] next_ev,
                         input int e_errs, input bit e_fv, input int e_fa, input logic [7:0] e_fd);
        int depth, n, resp, first_vld, last_req, last_resp, done_cyc, dones, hold;
        bit addr_ok;
        depth = d3 ? 3 : 4;
        for (int i = 0; i < 4; i++) ram[i] = img[8*i +: 8];
        lat = l;
        if (!chained) begin
            @(negedge clk);
            sel = d3;
            expv = ev;
            if (d3) start_b = 1'b1; else start_a = 1'b1;
        end
        @(negedge clk);
        start_a = 1'b0; start_b = 1'b0;
        n = 0; resp = 0; first_vld = -1; last_req = -1; last_resp = -1;
        done_cyc = -1; dones = 0; hold = 0; addr_ok = 1;
        for (int cyc = 0; cyc < 80; cyc++) begin
`ifdef BR_RAM_INIT_CHECKER_STALL_EN
            case (rmode)
                1: rdy = ($urandom_range(0, 3) != 0);
                2: begin
                    rdy = !(m_vld && m_addr == 2'd1 && hold < 2);
                    if (!rdy) hold++;
                end
                default: rdy = 1'b1;
            endcase
`else
            rdy = 1'b1;
`endif
            if (poke) begin
                if (d3) start_b = (cyc == 1 || cyc == 2); else start_a = (cyc == 1 || cyc == 2);
            end
            #1;
            if (cyc == 0) begin
                chk($sformatf("%s count cleared at start", nm), m_cnt, 0);
                chk($sformatf("%s first_error_valid cleared", nm), m_fev, 0);
                chk($sformatf("%s pass cleared", nm), m_pass, 0);
                chk($sformatf("%s busy after start", nm), m_busy, 1);
            end
            if (m_vld && first_vld < 0) first_vld = cyc;
            if (m_vld && rdy) begin
                if (n >= depth || m_addr != 2'(n)) addr_ok = 0;
                n++;
                last_req = cyc;
            end
            if (rdv && m_busy) begin
                resp++;
                if (resp == depth) last_resp = cyc;
            end
            if (m_done) begin
                dones++;
                if (done_cyc < 0) begin
                    done_cyc = cyc;
                    if (chain_out) begin
                        expv = next_ev;
                        if (d3) start_b = 1'b1; else start_a = 1'b1;
                        break;
                    end
                end
            end
            if (done_cyc >= 0 && cyc >= done_cyc + 2) break;
            @(negedge clk);
        end
        chk($sformatf("%s done seen", nm), done_cyc >= 0, 1);
        chk($sformatf("%s done pulse count", nm), dones, 1);
        chk($sformatf("%s done one cycle after last response", nm), done_cyc - last_resp, 1);
        chk($sformatf("%s address sequence", nm), addr_ok && (n == depth), 1);
        chk($sformatf("%s first request cycle", nm), first_vld, 0);
        if (rmode == 0) chk($sformatf("%s last request cycle", nm), last_req, depth - 1);
        chk($sformatf("%s busy after done", nm), m_busy, 0);
        chk($sformatf("%s error_count", nm), m_cnt, e_errs);
        chk($sformatf("%s first_error_valid", nm), m_fev, e_fv);
        if (e_fv) begin
            chk($sformatf("%s first_error_addr", nm), m_fea, e_fa);
            chk($sformatf("%s first_error_data", nm), m_fed, e_fd);
        end
        chk($sformatf("%s pass", nm), m_pass, e_errs == 0);
    endtask

    typedef struct packed {
        logic        d3;
        logic [31:0] img;
        logic [7:0]  ev;
        logic [1:0]  lat;
        logic [2:0]  errs;
        logic        fv;
        logic [1:0]  fa;
        logic [7:0]  fd;
    } vec_t;

    vec_t vecs [5];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, got no finish, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int  e, fa, trail;
        bit  fv, d3r, seen, bad;
        logic [7:0]  fd, ev;
        logic [31:0] img;
        int  l, rm;

        // Image byte i is RAM entry i.
        vecs[0] = '{1'b0, 32'hA5A5A5A5, 8'hA5, 2'd1, 3'd0, 1'b0, 2'd0, 8'h00};
        vecs[1] = '{1'b0, 32'hFF00A5A5, 8'hA5, 2'd1, 3'd2, 1'b1, 2'd2, 8'h00};
        vecs[2] = '{1'b1, 32'h00332211, 8'h44, 2'd0, 3'd3, 1'b1, 2'd0, 8'h11};
        vecs[3] = '{1'b0, 32'h5AA5A5A5, 8'hA5, 2'd3, 3'd1, 1'b1, 2'd3, 8'h5A};
        vecs[4] = '{1'b1, 32'hFFA5A5A5, 8'hA5, 2'd2, 3'd0, 1'b0, 2'd0, 8'h00};

        sel = 0; start_a = 0; start_b = 0; expv = 0; rdy = 1; extra_vld = 0; lat = 1;
        for (int i = 0; i < 4; i++) ram[i] = 8'h00;
        rst_n = 0;
        #12;
        chk("reset busy", m_busy, 0);
        chk("reset done", m_done, 0);
        chk("reset pass", m_pass, 0);
        chk("reset rd_addr_valid", m_vld, 0);
        chk("reset rd_addr", m_addr, 0);
        chk("reset error_count", m_cnt, 0);
        chk("reset first_error", {m_fev, m_fea, m_fed}, 0);
        @(negedge clk);
        rst_n = 1;
        repeat (2) @(negedge clk);

        for (int v = 0; v < 5; v++) begin
            sweep($sformatf("vec%0d", v), vecs[v].d3, vecs[v].img, vecs[v].ev, int'(vecs[v].lat), 0,
                  0, 0, 0, 8'h00, int'(vecs[v].errs), vecs[v].fv, int'(vecs[v].fa), vecs[v].fd);
        end

        // A start while busy is ignored; a start in the done cycle launches the next sweep with a new expected value.
        sweep("restart_a", 0, 32'hA5A5A500, 8'hA5, 1, 0, 1, 0, 1, 8'h3C, 1, 1, 0, 8'h00);
        sweep("restart_b", 0, 32'h3C3C003C, 8'h00, 1, 0, 0, 1, 0, 8'h00, 1, 1, 1, 8'h00);

        // Assert reset in the middle of a sweep. Trailing responses then arrive while the checker is IDLE.
        repeat (2) @(negedge clk);
        sel = 0; lat = 2;
        for (int i = 0; i < 4; i++) ram[i] = 8'hA5;
        expv = 8'h00; start_a = 1;
        @(negedge clk);
        start_a = 0;
        seen = 0;
        for (int c = 0; c < 10; c++) begin
            #1;
            if (m_vld && m_addr == 2'd1) begin
                seen = 1;
                break;
            end
            @(negedge clk);
        end
        chk("midreset reached addr 1", seen, 1);
        rst_n = 0;
        #1;
        chk("midreset busy", m_busy, 0);
        chk("midreset rd_addr_valid", m_vld, 0);
        chk("midreset rd_addr", m_addr, 0);
        chk("midreset error_count", m_cnt, 0);
        chk("midreset first_error", {m_fev, m_fea, m_fed}, 0);
        chk("midreset done/pass", {m_done, m_pass}, 0);
        @(negedge clk);
        rst_n = 1;
        trail = 0; bad = 0;
        for (int c = 0; c < 6; c++) begin
            extra_vld = (c == 3);
            #1;
            if (rdv) trail++;
            if (m_done || m_busy || m_cnt != 0 || m_fev) bad = 1;
            @(negedge clk);
        end
        extra_vld = 0;
        chk("midreset stray responses ignored", bad, 0);
        sweep("after_reset", 0, 32'hA5A5A5A5, 8'hA5, 2, 0, 0, 0, 0, 8'h00, 0, 0, 0, 8'h00);

`ifdef BR_RAM_INIT_CHECKER_STALL_EN
        sweep("stall_at_1", 0, 32'hA5A5A5A5, 8'hA5, 1, 2, 0, 0, 0, 8'h00, 0, 0, 0, 8'h00);
`endif

        for (int r = 0; r < 20; r++) begin
            d3r = 1'($urandom_range(0, 1));
            ev = 8'($urandom);
            img = {4{ev}};
            for (int i = 0; i < 4; i++) begin
                if ($urandom_range(0, 2) == 0) img[8*i +: 8] = 8'($urandom);
            end
            l = $urandom_range(0, 3);
            rm = 0;
`ifdef BR_RAM_INIT_CHECKER_STALL_EN
            rm = $urandom_range(0, 1);
`endif
            model(d3r, img, ev, e, fv, fa, fd);
            sweep($sformatf("rnd%0d", r), d3r, img, ev, l, rm, 0, 0, 0, 8'h00, e, fv, fa, fd);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
